uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, number of data bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter OVS, default 16, number of s_tick pulses per start, data or parity bit.
REQ-003 The block SHALL have parameter SB_TICK, default 16, number of s_tick pulses in the stop period (16/24/32 = 1/1.5/2 stop bits at OVS=16).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_start  input  1  request to send din; accepted only while tx_ready=1.
REQ-007 s_tick  input  1  oversampling enable from the external baud generator, one clk wide.
REQ-008 din  input  DBIT  data word to send; LSB is sent first.
REQ-009 par_mode  input  2  parity select: 00 none, 01 even, 10 odd, 11 none.
REQ-010 tx_ready  output  1  high only in IDLE; start is accepted this cycle.
REQ-011 tx_done_tick  output  1  one-clk pulse at the end of the stop period.
REQ-012 tx  output  1  serial line, registered, idle high.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-014 In IDLE, when tx_start=1, the block SHALL on the same edge capture din and par_mode into internal registers, clear the tick counter and enter START.
REQ-015 The block SHALL ignore tx_start outside IDLE, with no effect on the current frame or on the captured registers.
REQ-016 tx SHALL be registered and SHALL take the value of the current state on the edge after the state is entered: START 0, DATA shift_reg[0], PARITY parity bit, STOP 1, IDLE 1.
REQ-017 The tick counter SHALL advance only on s_tick=1 and SHALL hold when s_tick=0, so bit timing scales with the s_tick rate.
REQ-018 START SHALL last OVS ticks; it SHALL then go to DATA with the bit counter at 0.
REQ-019 Each DATA bit SHALL last OVS ticks; at the end of each bit, shift_reg SHALL shift right by 1 and the bit counter SHALL increment.
REQ-020 After bit DBIT-1, the block SHALL go to PARITY if the captured mode is 01 or 10, otherwise to STOP.
REQ-021 The PARITY bit SHALL be the XOR of the captured data for mode 01 (even) and the XNOR for mode 10 (odd); it SHALL be computed at capture time and SHALL last OVS ticks.
REQ-022 STOP SHALL last SB_TICK ticks; on its final s_tick the block SHALL assert tx_done_tick combinationally for exactly that one clk cycle and SHALL enter IDLE on that edge.
REQ-023 A new tx_start SHALL be acceptable no earlier than the cycle after tx_done_tick (back-to-back frames, with no extra idle bits when ticks are continuous).
REQ-024 The tick counter width SHALL be clog2(max(OVS,SB_TICK)), and the bit counter width SHALL be clog2(DBIT); counters SHALL never wrap mid-bit.
REQ-025 Frame length SHALL be (1+DBIT+P)*OVS+SB_TICK ticks, with P=1 when parity is enabled and 0 otherwise.

Reset
REQ-026 With reset=1 at a clock edge, the block SHALL enter IDLE, clear the tick counter, bit counter and shift register, and set tx=1.
REQ-027 Reset SHALL take priority over tx_start and s_tick; reset mid-frame SHALL abort the frame with no tx_done_tick, and tx_ready=1 after that edge.
REQ-028 tx_done_tick and tx_ready SHALL be 0 and 1 respectively during and after reset.

Structure
REQ-029 The state encoding and parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) SHALL live in the shared package uart_pkg, for reuse by the matching receiver.
REQ-030 The block SHALL be a single module with no sub-modules; the baud tick generator SHALL stay external.

Verification (DBIT=8, OVS=16, SB_TICK=16, s_tick every cycle unless stated)
REQ-031 din=8'hA5, par_mode=00 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles, and tx_done_tick on the 160th tick.
REQ-032 din=8'hA5, par_mode=01 then 10 -> parity bit 0 then 1, and tx_done_tick on the 176th tick.
REQ-033 tx_start with din=8'h3C during DATA of an 8'hA5 frame -> waveform unchanged, no second frame.
REQ-034 reset asserted during data bit 3 -> tx=1 and tx_ready=1 on the next edge, no tx_done_tick, then a clean 8'h5A frame.
REQ-035 s_tick every 4th cycle, SB_TICK=32 -> each bit lasts 64 cycles, the stop period lasts 128 cycles, and a back-to-back start 1 cycle after tx_done_tick produces no gap.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding and parity mode codes.
// Used by the transmitter here and by the matching receiver.
// Pure declarations, no logic.
package uart_pkg;

  // FSM state encoding (kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity mode codes; 2'b11 is treated as "none" as well
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // True when the mode inserts a parity bit after the data bits
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, DBIT data bits LSB first, optional parity, stop.
// Latency: tx follows the state one clk later; frame = (1+DBIT+P)*OVS+SB_TICK s_tick pulses.
// Backpressure: tx_start is taken only while tx_ready=1; requests in any other state are dropped.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] din,
  input  logic [1:0]      par_mode,
  output logic            tx_ready,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int TMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(DBIT);

  localparam logic [TW-1:0] OVS_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

  logic [2:0]      state_q, state_d;
  logic [TW-1:0]   tick_q,  tick_d;
  logic [BW-1:0]   bit_q,   bit_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [1:0]      mode_q,  mode_d;
  logic            par_q,   par_d;
  logic            tx_q,    tx_d;
  logic            done;

  // Next-state, counters, capture and line level for the current state
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    mode_d  = mode_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          shift_d = din;
          mode_d  = par_mode;
          // Parity is fixed at capture so later din changes cannot disturb it
          par_d   = (par_mode == PAR_ODD) ? ~(^din) : (^din);
          tick_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (tick_q == OVS_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (s_tick) begin
          if (tick_q == OVS_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = par_enabled(mode_q) ? ST_PARITY : ST_STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q;
        if (s_tick) begin
          if (tick_q == OVS_LAST) begin
            tick_d  = '0;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (tick_q == SB_LAST) begin
            done    = 1'b1;
            tick_d  = '0;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      mode_q  <= PAR_NONE;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Reset masks the handshake outputs so a frame cut short never reports done
  assign tx_ready     = (state_q == ST_IDLE) || reset;
  assign tx_done_tick = done && !reset;
  assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: one instance with ticks every clk (SB_TICK=16),
// one with ticks every 4th clk (SB_TICK=32). Expected line bits are queued when a
// frame is started and popped at mid-bit, counted in s_tick pulses.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic       sel;
  logic [7:0] din;
  logic [1:0] par_mode;
  logic [1:0] phase = 2'd0;

  logic start_a, start_b, s_tick_a, s_tick_b;
  logic rdy_a, rdy_b, done_a, done_b, tx_a, tx_b;
  logic rdy_m, done_m, tx_m, s_tick_m;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) phase <= phase + 2'd1;

  assign start_a  = tx_start & ~sel;
  assign start_b  = tx_start & sel;
  assign s_tick_a = ~sel;
  assign s_tick_b = sel & (phase == 2'd0);
  assign rdy_m    = sel ? rdy_b  : rdy_a;
  assign done_m   = sel ? done_b : done_a;
  assign tx_m     = sel ? tx_b   : tx_a;
  assign s_tick_m = sel ? s_tick_b : s_tick_a;

  uart_tx_param #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut_a (
    .clk(clk), .reset(reset), .tx_start(start_a), .s_tick(s_tick_a),
    .din(din), .par_mode(par_mode),
    .tx_ready(rdy_a), .tx_done_tick(done_a), .tx(tx_a)
  );

  uart_tx_param #(.DBIT(8), .OVS(16), .SB_TICK(32)) dut_b (
    .clk(clk), .reset(reset), .tx_start(start_b), .s_tick(s_tick_b),
    .din(din), .par_mode(par_mode),
    .tx_ready(rdy_b), .tx_done_tick(done_b), .tx(tx_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send one frame from the cycle after a clk edge; returns in the cycle after tx_done_tick.
  // inj >= 0 drives a stray tx_start with different data when that many ticks have elapsed.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] m, input int sb,
                           input int tp, input int inj);
    int   p, ones, total, ticks, cyc, k;
    bit   done, newt, injd;
    logic b;
    p    = (m == 2'b01 || m == 2'b10) ? 1 : 0;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (m == 2'b01) exp_q.push_back(ones % 2 == 1);
    if (m == 2'b10) exp_q.push_back(ones % 2 == 0);
    exp_q.push_back(1'b1);
    total = (9 + p) * 16 + sb;

    chk("ready_before_start", rdy_m, 1);
    din      = d;
    par_mode = m;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    chk("ready_after_accept", rdy_m, 0);

    ticks = 0; cyc = 1; k = 0; done = 1'b0; injd = 1'b0;
    while (!done && cyc < total * tp + 16) begin
      if (inj >= 0 && !injd && ticks == inj) begin
        din = 8'h3C; par_mode = 2'b10; tx_start = 1'b1; injd = 1'b1;
      end
      if (done_m) begin
        done = 1'b1;
        chk("done_tick_index", ticks + 1, total);
        chk("done_cycle_window", (cyc > (total - 1) * tp) && (cyc <= total * tp), 1);
      end
      newt = s_tick_m;
      if (newt) ticks++;
      @(posedge clk); #1;
      cyc++;
      tx_start = 1'b0;
      if (cyc == 2) chk("start_level_next_edge", tx_m, 0);
      if (newt && exp_q.size() > 0 && ticks == k * 16 + 8) begin
        b = exp_q.pop_front();
        chk($sformatf("line_bit%0d", k), tx_m, b);
        k++;
      end
    end
    chk("done_seen", done, 1);
    chk("all_bits_sampled", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int   cnt;
    logic [7:0] dv;
    reset = 1'b1; tx_start = 1'b0; sel = 1'b0; din = 8'h00; par_mode = 2'b00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx_m, 1);
    chk("reset_ready", rdy_m, 1);
    chk("reset_done", done_m, 0);
    chk("reset_tx_b", tx_b, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Plain frame, then even and odd parity back to back
    run_frame(8'hA5, 2'b00, 16, 1, -1);
    run_frame(8'hA5, 2'b01, 16, 1, -1);
    run_frame(8'hA5, 2'b10, 16, 1, -1);

    // Stray start during DATA must not disturb the frame or launch another
    run_frame(8'hA5, 2'b00, 16, 1, 40);
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done_m || !rdy_m || !tx_m) cnt++;
    end
    chk("no_second_frame", cnt, 0);

    // Reset in the middle of data bit 3
    dv = 8'hA5;
    din = dv; par_mode = 2'b00; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (72) @(posedge clk);
    #1;
    chk("pre_reset_bit3", tx_m, dv[3]);
    reset = 1'b1;
    #1;
    chk("reset_mid_done", done_m, 0);
    @(posedge clk); #1;
    chk("abort_tx_high", tx_m, 1);
    chk("abort_ready", rdy_m, 1);
    reset = 1'b0;
    cnt = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done_m) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    run_frame(8'h5A, 2'b00, 16, 1, -1);

    // Slow ticks, 2 stop bits, back-to-back frames
    sel = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("slow_idle_ready", rdy_m, 1);
    run_frame(8'hA5, 2'b00, 32, 4, -1);
    run_frame(8'h3C, 2'b01, 32, 4, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
